countdown_timer: RTL and testbench

//  Loadable 0..59 s countdown timer, the down-counting counterpart of the stopwatch.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/segment7.sv | 24 ++
 rtl/countdown_timer.sv | 161 ++++++++++++++++
 tb/tb_countdown_timer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;

  localparam logic [2:0] TENS_MAX = 3'd5;
  localparam logic [3:0] ONES_MAX = 4'd9;

  function automatic logic [2:0] clamp_tens(input logic [2:0] t);
    return (t > TENS_MAX) ? TENS_MAX : t;
  endfunction

  function automatic logic [3:0] clamp_ones(input logic [3:0] o);
    return (o > ONES_MAX) ? ONES_MAX : o;
  endfunction

endpackage

// File: rtl/segment7.sv
// BCD to 7-segment encoder (active-high {g,f,e,d,c,b,a}); non-BCD codes show blank.
module segment7 (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_bcd)
      4'd0:    o_seg = 7'h3F;
      4'd1:    o_seg = 7'h06;
      4'd2:    o_seg = 7'h5B;
      4'd3:    o_seg = 7'h4F;
      4'd4:    o_seg = 7'h66;
      4'd5:    o_seg = 7'h6D;
      4'd6:    o_seg = 7'h7D;
      4'd7:    o_seg = 7'h07;
      4'd8:    o_seg = 7'h7F;
      4'd9:    o_seg = 7'h6F;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable 0..59 s BCD countdown timer with button edge detect and registered 7-seg outputs.
// Define DONE_BLINK_EN to blink the "00" display while in DONE.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [2:0] set_tens,
  input  logic [3:0] set_ones,
  output logic [6:0] OUT10,
  output logic [6:0] OUT1,
  output logic       running,
  output logic       done
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);
`ifdef DONE_BLINK_EN
  localparam logic [PW-1:0] PSC_HALF = PW'(DIV / 2);
`endif

  state_e        r_state;
  logic [PW-1:0] r_psc;
  logic [2:0]    r_tens;
  logic [3:0]    r_ones;
  logic          r_start_q;
  logic          r_pause_q;
  logic          r_load_q;
  logic [6:0]    r_out10;
  logic [6:0]    r_out1;

  logic       w_start_ev;
  logic       w_pause_ev;
  logic       w_load_ev;
  logic       w_nonzero;
  logic       w_blank;
  logic [6:0] w_seg10;
  logic [6:0] w_seg1;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_pause_q <= 1'b0;
      r_load_q  <= 1'b0;
    end else begin
      r_start_q <= start;
      r_pause_q <= pause;
      r_load_q  <= load;
    end
  end

  assign w_start_ev = start & ~r_start_q;
  assign w_pause_ev = pause & ~r_pause_q;
  assign w_load_ev  = load & ~r_load_q;
  assign w_nonzero  = (r_tens != 3'd0) || (r_ones != 4'd0);

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_psc   <= '0;
      r_tens  <= 3'd0;
      r_ones  <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load_ev) begin
            r_tens <= clamp_tens(set_tens);
            r_ones <= clamp_ones(set_ones);
          end else if (w_start_ev && w_nonzero) begin
            r_state <= RUN;
            r_psc   <= '0;
          end
        end
        RUN: begin
          // Pause wins over a tick; the prescaler is left frozen for resume.
          if (w_pause_ev) begin
            r_state <= PAUSE;
          end else if (r_psc == PSC_LAST) begin
            r_psc <= '0;
            if (r_ones != 4'd0) begin
              r_ones <= r_ones - 4'd1;
            end else begin
              r_ones <= ONES_MAX;
              r_tens <= r_tens - 3'd1;
            end
            if ((r_tens == 3'd0) && (r_ones == 4'd1)) begin
              r_state <= DONE;
            end
          end else begin
            r_psc <= r_psc + 1'b1;
          end
        end
        PAUSE: begin
          if (w_load_ev) begin
            r_tens  <= clamp_tens(set_tens);
            r_ones  <= clamp_ones(set_ones);
            r_psc   <= '0;
            r_state <= IDLE;
          end else if (w_start_ev) begin
            r_state <= RUN;
          end
        end
        DONE: begin
          if (w_load_ev) begin
            r_tens  <= clamp_tens(set_tens);
            r_ones  <= clamp_ones(set_ones);
            r_psc   <= '0;
            r_state <= IDLE;
          end else begin
`ifdef DONE_BLINK_EN
            r_psc <= (r_psc == PSC_LAST) ? '0 : r_psc + 1'b1;
`else
            r_psc <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  segment7 u_seg_tens (
    .i_bcd ({1'b0, r_tens}),
    .o_seg (w_seg10)
  );

  segment7 u_seg_ones (
    .i_bcd (r_ones),
    .o_seg (w_seg1)
  );

`ifdef DONE_BLINK_EN
  // First half of each prescaler period shows "00", second half is blank.
  assign w_blank = (r_state == DONE) && (r_psc >= PSC_HALF);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_out10 <= SEG_ZERO;
      r_out1  <= SEG_ZERO;
    end else begin
      r_out10 <= w_blank ? SEG_BLANK : w_seg10;
      r_out1  <= w_blank ? SEG_BLANK : w_seg1;
    end
  end

  assign OUT10   = r_out10;
  assign OUT1    = r_out1;
  assign running = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: seconds-level reference model feeds a queue,
// a negedge monitor compares every cycle.
module tb_countdown_timer;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [2:0] set_tens = 3'd0;
  logic [3:0] set_ones = 4'd0;
  logic [6:0] OUT10;
  logic [6:0] OUT1;
  logic       running;
  logic       done;

  countdown_timer #(
    .CLK_HZ  (10),
    .TICK_HZ (1)
  ) dut (
    .clk_50   (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .load     (load),
    .set_tens (set_tens),
    .set_ones (set_ones),
    .OUT10    (OUT10),
    .OUT1     (OUT1),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] t;
    logic [6:0] o;
    logic       run;
    logic       dn;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_e;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int clamped_value(input logic [2:0] t, input logic [3:0] o);
    int ti;
    int oi;
    ti = (int'(t) > 5) ? 5 : int'(t);
    oi = (int'(o) > 9) ? 9 : int'(o);
    return ti * 10 + oi;
  endfunction

  // Reference model: remaining time kept as whole seconds; every DIV running cycles
  // remove one second.
  initial begin : model
    mode_e mode;
    int    value;
    int    acc;
    int    dcyc;
    logic  p_start;
    logic  p_pause;
    logic  p_load;
    logic  ev_s;
    logic  ev_p;
    logic  ev_l;
    logic  blank;
    exp_t  e;
    mode = M_IDLE; value = 0; acc = 0; dcyc = 0;
    p_start = 1'b0; p_pause = 1'b0; p_load = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mode = M_IDLE; value = 0; acc = 0; dcyc = 0;
        p_start = 1'b0; p_pause = 1'b0; p_load = 1'b0;
        exp_q.delete();
        e.t = seg_of(0); e.o = seg_of(0); e.run = 1'b0; e.dn = 1'b0;
        exp_q.push_back(e);
      end else begin
`ifdef DONE_BLINK_EN
        blank = (mode == M_DONE) && ((dcyc % DIV) >= DIV / 2);
`else
        blank = 1'b0;
`endif
        e.t = blank ? 7'h00 : seg_of(value / 10);
        e.o = blank ? 7'h00 : seg_of(value % 10);
        ev_s = start & ~p_start;
        ev_p = pause & ~p_pause;
        ev_l = load & ~p_load;
        p_start = start; p_pause = pause; p_load = load;
        case (mode)
          M_IDLE: begin
            if (ev_l) value = clamped_value(set_tens, set_ones);
            else if (ev_s && value != 0) begin
              mode = M_RUN;
              acc = 0;
            end
          end
          M_RUN: begin
            if (ev_p) mode = M_PAUSE;
            else begin
              acc++;
              if (acc % DIV == 0) begin
                value--;
                if (value == 0) begin
                  mode = M_DONE;
                  dcyc = 0;
                end
              end
            end
          end
          M_PAUSE: begin
            if (ev_l) begin
              value = clamped_value(set_tens, set_ones);
              acc = 0;
              mode = M_IDLE;
            end else if (ev_s) mode = M_RUN;
          end
          default: begin
            if (ev_l) begin
              value = clamped_value(set_tens, set_ones);
              mode = M_IDLE;
            end else dcyc++;
          end
        endcase
        e.run = (mode == M_RUN);
        e.dn  = (mode == M_DONE);
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({OUT10, OUT1, running, done} !== e) begin
          n_fails++;
          $display("FAIL outputs @%0t: got OUT10=%h OUT1=%h running=%b done=%b, want %h %h %b %b",
                   $time, OUT10, OUT1, running, done, e.t, e.o, e.run, e.dn);
        end
      end
    end
  end

  task automatic press(input logic s, input logic p, input logic l);
    @(posedge clk);
    #1;
    start = s; pause = p; load = l;
    @(posedge clk);
    #1;
    start = 1'b0; pause = 1'b0; load = 1'b0;
  endtask

  task automatic set_val(input logic [2:0] t, input logic [3:0] o);
    set_tens = t;
    set_ones = o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin : stim
    int n;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    set_val(3'd3, 4'd5);
    press(1'b0, 1'b0, 1'b1);
    idle(3);

    press(1'b1, 1'b0, 1'b0);
    idle(65);

    press(1'b0, 1'b1, 1'b0);
    idle(50);
    press(1'b1, 1'b0, 1'b0);
    idle(17);

    // Pause then reload to leave RUN, then time a 02 countdown to DONE.
    press(1'b0, 1'b1, 1'b0);
    set_val(3'd0, 4'd2);
    press(1'b0, 1'b0, 1'b1);
    idle(2);
    @(posedge clk);
    #1 start = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      n++;
      if (done) break;
    end
    n_checks++;
    if (n - 1 != 20) begin
      n_fails++;
      $display("FAIL done_latency: got %0d cycles after RUN entry, want 20", n - 1);
    end
    idle(3);
    press(1'b1, 1'b0, 1'b0);
    idle(12);

    set_val(3'd7, 4'd12);
    press(1'b0, 1'b0, 1'b1);
    idle(3);
    set_val(3'd0, 4'd0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    idle(5);
    set_val(3'd4, 4'd1);
    press(1'b1, 1'b0, 1'b1);
    idle(5);

    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1: begin
          set_val(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
          press(1'b0, 1'b0, 1'b1);
        end
        2, 3: press(1'b1, 1'b0, 1'b0);
        4: press(1'b0, 1'b1, 1'b0);
        5: begin
          set_val(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
          press(1'b1, 1'b0, 1'b1);
        end
        6: idle(int'($urandom_range(100, 250)));
        default: idle(int'($urandom_range(1, 40)));
      endcase
    end

    // Bring to RUN, then assert reset asynchronously between edges.
    press(1'b0, 1'b1, 1'b0);
    set_val(3'd5, 4'd9);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    idle(37);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({OUT10, OUT1, running, done} !== {7'h3F, 7'h3F, 1'b0, 1'b0}) begin
      n_fails++;
      $display("FAIL async_reset: got OUT10=%h OUT1=%h running=%b done=%b, want 3f 3f 0 0",
               OUT10, OUT1, running, done);
    end
    idle(2);
    #1 rst = 1'b0;
    set_val(3'd0, 4'd3);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    idle(45);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
